// File: rtl/rle_compressor.sv
// Run-length encoder for 1-bit pixel frames; emits {pixel, count} run words
// through a single-entry output register with valid/ready handshakes on both sides.
module rle_compressor #(
   parameter int unsigned FRAME_PIXELS = 16384,
   parameter int unsigned COUNT_W      = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               pix_valid,
   input  logic               pix_data,
   output logic               pix_ready,
   output logic               word_valid,
   output logic [COUNT_W:0]   word_data,
   input  logic               word_ready,
   output logic               busy,
   output logic               done,
   output logic [15:0]        words_emitted
);

   localparam int unsigned      WORD_W   = COUNT_W + 1;
   localparam logic [COUNT_W-1:0] CNT_MAX = '1;
   localparam logic [15:0]      LAST_IDX = 16'(FRAME_PIXELS - 1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

   state_t              state_q, state_d;
   logic                run_bit_q, run_bit_d;
   logic [COUNT_W-1:0]  run_cnt_q, run_cnt_d;
   logic [15:0]         pix_idx_q, pix_idx_d;
   logic                load;
   logic [WORD_W-1:0]   load_data;
   logic                reg_free;
   logic                consume;
   logic                accept;

   assign reg_free = !word_valid || word_ready;
   assign consume  = word_valid && word_ready;
   assign accept   = pix_valid && pix_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (accept && (pix_idx_q == LAST_IDX)) state_d = FLUSH;
         FLUSH:   if (reg_free) state_d = DRAIN;
         DRAIN:   if (consume) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs and run-tracking updates
   always_comb begin
      pix_ready = 1'b0;
      busy      = (state_q != IDLE);
      done      = 1'b0;
      load      = 1'b0;
      load_data = {run_bit_q, run_cnt_q};
      run_bit_d = run_bit_q;
      run_cnt_d = run_cnt_q;
      pix_idx_d = pix_idx_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               run_bit_d = 1'b0;
               run_cnt_d = '0;
               pix_idx_d = '0;
            end
         end
         RUN: begin
            pix_ready = reg_free;
            if (reg_free && pix_valid) begin
               pix_idx_d = pix_idx_q + 16'd1;
               if (run_cnt_q == '0) begin
                  run_bit_d = pix_data;
                  run_cnt_d = COUNT_W'(1);
               end else if ((pix_data == run_bit_q) && (run_cnt_q != CNT_MAX)) begin
                  run_cnt_d = run_cnt_q + COUNT_W'(1);
               end else begin
                  // Run ends: emit it and start a new run with this pixel
                  load      = 1'b1;
                  run_bit_d = pix_data;
                  run_cnt_d = COUNT_W'(1);
               end
            end
         end
         FLUSH:   load = reg_free;
         DRAIN:   done = consume;
         default: ;
      endcase
   end

   // Run state, output register and word counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_bit_q     <= 1'b0;
         run_cnt_q     <= '0;
         pix_idx_q     <= '0;
         word_valid    <= 1'b0;
         word_data     <= '0;
         words_emitted <= '0;
      end else begin
         run_bit_q <= run_bit_d;
         run_cnt_q <= run_cnt_d;
         pix_idx_q <= pix_idx_d;
         if (load) begin
            word_valid <= 1'b1;
            word_data  <= load_data;
         end else if (consume) begin
            word_valid <= 1'b0;
         end
         if ((state_q == IDLE) && start)
            words_emitted <= '0;
         else if (consume && (words_emitted != 16'hFFFF))
            words_emitted <= words_emitted + 16'd1;
      end
   end

endmodule

// File: doc/rle_compressor.md
Name: rle_compressor

Overview:
- Run-length encoder for binary (1-bit) image frames; produces the 16-bit run-word format used by the IO decompression path.
- Word format: bit[COUNT_W] = pixel value; bits[COUNT_W-1:0] = run length, 1..2^COUNT_W-1.
- Pixels stream in via a valid/ready handshake; run words stream out via a valid/ready handshake. The words are written to the command-data store that the decompressor reads back.

Parameters:
- FRAME_PIXELS, 16384, pixels per frame (128x128); legal range 1..65535.
- COUNT_W, 15, run-count field width; word width = COUNT_W+1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse, begins a frame; ignored unless IDLE.
- pix_valid  in  1  pixel present.
- pix_data  in  1  pixel value.
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready.
- word_valid  out  1  run word present.
- word_data  out  COUNT_W+1  run word {bit, count}.
- word_ready  in  1  word consumed when word_valid && word_ready.
- busy  out  1  high in any state other than IDLE.
- done  out  1  1-cycle pulse when the final word of the frame is consumed.
- words_emitted  out  16  words consumed this frame; cleared on accepted start.

Behaviour:
- Reset, asynchronous: state=IDLE. All outputs 0. Run bit, run count and pixel index = 0. Any partial frame is discarded.
- States: IDLE, RUN, FLUSH, DRAIN.
- IDLE -> RUN on start. Clears pixel index, run count and words_emitted.
- Output register: a single entry (word_valid/word_data). It is free when !word_valid || word_ready.
- pix_ready = (state==RUN) && output register free. It is deliberately conservative and combinational from state, word_valid and word_ready only.
- Accepted pixel p in RUN:
  - run count==0: run bit=p, count=1.
  - p==run bit and count<2^COUNT_W-1: count+1.
  - p!=run bit or count==2^COUNT_W-1: load output register with {run bit, count}; new run bit=p, count=1.
- Output word latency: the word is valid the cycle after the accepted pixel that terminates the run.
- Pixel index increments on each accepted pixel. The accept with index==FRAME_PIXELS-1 moves the state to FLUSH; that pixel is processed per the rules above.
- FLUSH: when the output register is free, load {run bit, count}; -> DRAIN. The run count is never 0 here.
- DRAIN: pix_ready=0. On word_valid && word_ready: done=1 for one cycle, word_valid=0 -> IDLE.
- Output register hold: word_valid and word_data are held stable until consumed. A new load and consumption of the old word may occur in the same cycle, leaving word_valid=1 with the new data.
- Clearing the register: word_valid clears on consume with no new load.
- words_emitted: +1 on every consumed word. It saturates at 16'hFFFF and holds its value after done until the next start.
- Pixels offered outside RUN are not accepted (pix_ready=0). Words are never dropped or duplicated.

Test Plan:
- Default parameters, start, 16384 pixels of 0, word_ready=1 -> exactly one word 16'h4000. done pulses once, words_emitted=1. Repeat with all 1s -> 16'hC000.
- Alternating 0,1,... for 16384 pixels -> 16384 words alternating 16'h0001/16'h8001. words_emitted=16384, busy drops the cycle after done.
- COUNT_W=3, FRAME_PIXELS=20, all 1s -> words 4'hF, 4'hF, 4'hE in order (max-run split), then done.
- 16383 zeros then a single 1 -> words 16'h3FFF then 16'h8001. done is asserted in the cycle the second word is consumed.
- Backpressure: random pattern, word_ready randomly low ~50% -> pix_ready=0 whenever word_valid && !word_ready; word_data stable while stalled. The decoded word stream reproduces the input bitmap exactly, with run counts summing to 16384.
- Assert rst_n low mid-frame (after 5000 pixels) -> all outputs 0 immediately, state IDLE. A following start and an all-0 frame yields exactly 16'h4000, words_emitted=1.
